// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg
// Shared definitions for the key pulse generator: channel FSM state
// encoding, counter width and the default debounce / hold / repeat
// cycle counts for a 16 MHz clock.
package key_pulse_pkg;

  localparam int CNT_W = 24;

  // 3-bit state constants kept as plain localparams so legacy code
  // comparing against raw encodings still lines up.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRESS   = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_REPEAT  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] DEF_DEB_CYCLES    = 24'd32000;    // 2 ms
  localparam logic [CNT_W-1:0] DEF_HOLD_CYCLES   = 24'd8000000;  // 0.5 s
  localparam logic [CNT_W-1:0] DEF_REPEAT_CYCLES = 24'd2000000;  // 125 ms

  // True while the key counts as debounced-pressed.
  function automatic logic is_held(input logic [2:0] state);
    return (state == S_HOLD) || (state == S_REPEAT);
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel
// One key: 2-flop synchronizer, debounce / hold / auto-repeat FSM and
// its shared 24-bit counter.
// Ports:
//   clk_16   in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_key_n  in   raw active-low key, asynchronous to clk_16
//   o_fire   out  combinational event, one cycle, registered by the top
//   o_held   out  registered "key debounced-pressed" flag
module key_channel
  import key_pulse_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter logic [CNT_W-1:0] HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk_16,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_fire,
  output logic o_held
);

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] DEB_LAST = DEB_CYCLES - CNT_ONE;
  localparam logic [CNT_W-1:0] HLD_LAST = HOLD_CYCLES - CNT_ONE;
  localparam logic [CNT_W-1:0] REP_LAST = REPEAT_CYCLES - CNT_ONE;

  logic [1:0]       r_sync;
  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_low;
  logic             w_fire;
  logic             r_held;

  // Reset to 1 so a key is seen as released until proven otherwise.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
    end
  end

  assign w_low = ~r_sync[1];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_low) begin
          // The sample that leaves IDLE is already the first low one.
          w_state_next = S_PRESS;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next = '0;
        end
      end
      S_PRESS: begin
        if (!w_low) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = S_HOLD;
          w_fire       = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (!w_low) begin
          w_state_next = S_RELEASE;
          w_cnt_next   = CNT_ONE;
        end else if (r_cnt == HLD_LAST) begin
          w_state_next = S_REPEAT;
          w_fire       = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_REPEAT: begin
        if (!w_low) begin
          w_state_next = S_RELEASE;
          w_cnt_next   = CNT_ONE;
        end else if (r_cnt == REP_LAST) begin
          w_fire     = 1'b1;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_RELEASE: begin
        // A low sample restarts the release debounce instead of
        // re-arming a press, so bouncy releases never fire.
        if (w_low) begin
          w_cnt_next = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Decoded from the next state so the flag rises together with
      // the first output pulse.
      r_held  <= is_held(w_state_next);
    end
  end

  assign o_fire = w_fire;
  assign o_held = r_held;

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
// Conditions the up/down DE-board keys into clean single-cycle count
// events with hold-to-auto-repeat.
// Ports:
//   clk_16     in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_up_n   in   raw up key, active-low
//   key_dn_n   in   raw down key, active-low
//   en         in   pulse enable (0 drops events)
//   inc_pulse  out  one-cycle count-up event
//   dec_pulse  out  one-cycle count-down event
//   up_held    out  up key debounced-pressed
//   dn_held    out  down key debounced-pressed
module key_pulse_gen
  import key_pulse_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter logic [CNT_W-1:0] HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk_16,
  input  logic rst_n,
  input  logic key_up_n,
  input  logic key_dn_n,
  input  logic en,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic up_held,
  output logic dn_held
);

  // Channel 0 = up, channel 1 = down.
  logic [1:0] w_key_n;
  logic [1:0] w_fire;
  logic [1:0] w_held;
  logic       r_inc;
  logic       r_dec;

  assign w_key_n = {key_dn_n, key_up_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      key_channel #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_chan (
        .clk_16 (clk_16),
        .rst_n  (rst_n),
        .i_key_n(w_key_n[gi]),
        .o_fire (w_fire[gi]),
        .o_held (w_held[gi])
      );
    end
  endgenerate

  // Coincident events cancel: the countdown must never see both.
  // Masked events are simply dropped.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
    end else begin
      r_inc <= en & w_fire[0] & ~w_fire[1];
      r_dec <= en & w_fire[1] & ~w_fire[0];
    end
  end

  assign inc_pulse = r_inc;
  assign dec_pulse = r_dec;
  assign up_held   = w_held[0];
  assign dn_held   = w_held[1];

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen
// Directed scenarios with DEB=4, HOLD=20, REPEAT=8. Cycle index k is
// relative to the cycle in which a key input is changed; a change in
// cycle k reaches the FSM at k+2, so the first pulse lands at k+6.
module tb_key_pulse_gen;

  logic clk_16   = 1'b0;
  logic rst_n    = 1'b0;
  logic key_up_n = 1'b1;
  logic key_dn_n = 1'b1;
  logic en       = 1'b1;
  logic inc_pulse;
  logic dec_pulse;
  logic up_held;
  logic dn_held;

  int tests = 0;
  int fails = 0;

  key_pulse_gen #(
    .DEB_CYCLES   (24'd4),
    .HOLD_CYCLES  (24'd20),
    .REPEAT_CYCLES(24'd8)
  ) dut (
    .clk_16   (clk_16),
    .rst_n    (rst_n),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .en       (en),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .up_held  (up_held),
    .dn_held  (dn_held)
  );

  always #5 clk_16 = ~clk_16;

  task automatic tick();
    @(posedge clk_16);
    #1;
  endtask

  task automatic settle();
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    en       = 1'b1;
    repeat (15) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if ({inc_pulse, dec_pulse, up_held, dn_held} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs got %b exp 0000", {inc_pulse, dec_pulse, up_held, dn_held});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tests++;
      if ({inc_pulse, dec_pulse, up_held, dn_held} !== 4'b0000) begin
        fails++;
        $display("FAIL idle_outputs k=%0d got %b exp 0000", k, {inc_pulse, dec_pulse, up_held, dn_held});
      end
      tick();
    end
    $display("[TB] reset done");
  endtask

  // Up held for 10 cycles: one pulse at 6, held 6..12.
  task automatic test_clean_press();
    logic e_inc, e_held;
    for (int k = 0; k <= 20; k++) begin
      e_inc  = (k == 6);
      e_held = (k >= 6) && (k <= 12);
      tests++;
      if (inc_pulse !== e_inc) begin
        fails++;
        $display("FAIL clean_inc k=%0d got %b exp %b", k, inc_pulse, e_inc);
      end
      tests++;
      if (up_held !== e_held) begin
        fails++;
        $display("FAIL clean_held k=%0d got %b exp %b", k, up_held, e_held);
      end
      tests++;
      if (dec_pulse !== 1'b0) begin
        fails++;
        $display("FAIL clean_dec k=%0d got %b exp 0", k, dec_pulse);
      end
      key_up_n = (k < 10) ? 1'b0 : 1'b1;
      tick();
    end
    settle();
    $display("[TB] clean press done");
  endtask

  // 3-cycle low/high runs never complete debounce; stable low from 12.
  task automatic test_bounce();
    logic e_inc;
    for (int k = 0; k <= 24; k++) begin
      e_inc = (k == 18);
      tests++;
      if (inc_pulse !== e_inc) begin
        fails++;
        $display("FAIL bounce_inc k=%0d got %b exp %b", k, inc_pulse, e_inc);
      end
      if (k >= 12) key_up_n = 1'b0;
      else         key_up_n = ((k / 3) % 2 == 1) ? 1'b1 : 1'b0;
      tick();
    end
    settle();
    $display("[TB] bounce done");
  endtask

  // Down held 60 cycles, then bouncy release.
  task automatic test_repeat();
    logic e_dec, e_held;
    for (int k = 0; k <= 75; k++) begin
      e_dec  = (k == 6) || (k == 26) || (k == 34) || (k == 42) || (k == 50) || (k == 58);
      e_held = (k >= 6) && (k <= 62);
      tests++;
      if (dec_pulse !== e_dec) begin
        fails++;
        $display("FAIL repeat_dec k=%0d got %b exp %b", k, dec_pulse, e_dec);
      end
      tests++;
      if (dn_held !== e_held) begin
        fails++;
        $display("FAIL repeat_held k=%0d got %b exp %b", k, dn_held, e_held);
      end
      tests++;
      if (inc_pulse !== 1'b0) begin
        fails++;
        $display("FAIL repeat_inc k=%0d got %b exp 0", k, inc_pulse);
      end
      if (k < 60)                   key_dn_n = 1'b0;
      else if (k == 61 || k == 63)  key_dn_n = 1'b0;
      else                          key_dn_n = 1'b1;
      tick();
    end
    settle();
    $display("[TB] repeat done");
  endtask

  task automatic test_simultaneous();
    logic e_inc, e_dec;
    // Same-cycle press: every event coincides and is suppressed.
    for (int k = 0; k <= 55; k++) begin
      tests++;
      if ({inc_pulse, dec_pulse} !== 2'b00) begin
        fails++;
        $display("FAIL simul_pulses k=%0d got %b exp 00", k, {inc_pulse, dec_pulse});
      end
      if (k == 10) begin
        tests++;
        if ({up_held, dn_held} !== 2'b11) begin
          fails++;
          $display("FAIL simul_held got %b exp 11", {up_held, dn_held});
        end
      end
      key_up_n = (k < 40) ? 1'b0 : 1'b1;
      key_dn_n = (k < 40) ? 1'b0 : 1'b1;
      tick();
    end
    settle();
    // Down one cycle after up: pulses on consecutive cycles.
    for (int k = 0; k <= 30; k++) begin
      e_inc = (k == 6);
      e_dec = (k == 7);
      tests++;
      if (inc_pulse !== e_inc) begin
        fails++;
        $display("FAIL offset_inc k=%0d got %b exp %b", k, inc_pulse, e_inc);
      end
      tests++;
      if (dec_pulse !== e_dec) begin
        fails++;
        $display("FAIL offset_dec k=%0d got %b exp %b", k, dec_pulse, e_dec);
      end
      key_up_n = (k < 15) ? 1'b0 : 1'b1;
      key_dn_n = (k >= 1 && k < 15) ? 1'b0 : 1'b1;
      tick();
    end
    settle();
    $display("[TB] simultaneous done");
  endtask

  // First event masked, enable restored before the first repeat.
  task automatic test_enable();
    logic e_inc, e_held;
    for (int k = 0; k <= 30; k++) begin
      e_inc  = (k == 26);
      e_held = (k >= 6);
      tests++;
      if (inc_pulse !== e_inc) begin
        fails++;
        $display("FAIL enable_inc k=%0d got %b exp %b", k, inc_pulse, e_inc);
      end
      tests++;
      if (up_held !== e_held) begin
        fails++;
        $display("FAIL enable_held k=%0d got %b exp %b", k, up_held, e_held);
      end
      key_up_n = 1'b0;
      en       = (k >= 10) ? 1'b1 : 1'b0;
      tick();
    end
    settle();
    $display("[TB] enable done");
  endtask

  task automatic test_reset_repeat();
    logic e_inc, e_held;
    for (int k = 0; k <= 26; k++) begin
      e_inc  = (k == 6) || (k == 26);
      e_held = (k >= 6);
      tests++;
      if (inc_pulse !== e_inc) begin
        fails++;
        $display("FAIL rstrep_inc k=%0d got %b exp %b", k, inc_pulse, e_inc);
      end
      tests++;
      if (up_held !== e_held) begin
        fails++;
        $display("FAIL rstrep_held k=%0d got %b exp %b", k, up_held, e_held);
      end
      key_up_n = 1'b0;
      if (k < 26) tick();
    end
    // Asserted mid-cycle while the repeat pulse is high.
    rst_n = 1'b0;
    #1;
    tests++;
    if ({inc_pulse, up_held} !== 2'b00) begin
      fails++;
      $display("FAIL async_reset got %b exp 00", {inc_pulse, up_held});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      e_inc  = (k == 6);
      e_held = (k >= 6);
      tests++;
      if (inc_pulse !== e_inc) begin
        fails++;
        $display("FAIL postrst_inc k=%0d got %b exp %b", k, inc_pulse, e_inc);
      end
      tests++;
      if (up_held !== e_held) begin
        fails++;
        $display("FAIL postrst_held k=%0d got %b exp %b", k, up_held, e_held);
      end
      tick();
    end
    settle();
    $display("[TB] reset in repeat done");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_enable();
    test_reset_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
